// File: rtl/drum_result_decoder_if.sv
// drum_result_decoder_if
//   Bundles the beat input and result output handshakes of one DRUM result
//   decoder lane.
//   master : producer/consumer side (array column + output buffer)
//   slave  : the decoder itself
//   Signals:
//     in_valid/in_ready          beat handshake
//     in_mant                    unsigned mantissa product, 2*MULT_DW bits
//     in_sign                    product sign, 1 = negative
//     in_a_shamt/in_b_shamt      operand truncation shifts
//     in_last                    final term of the packet
//     out_valid/out_ready        result handshake
//     out_data                   signed packet sum, ACC_W bits
//     out_count                  terms in packet, saturating, LEN_W bits
//     out_ovf                    accumulator overflowed during the packet
interface drum_result_decoder_if #(
    parameter int MULT_DW = 4,
    parameter int A_BW    = 8,
    parameter int B_BW    = 8,
    parameter int ACC_W   = 24,
    parameter int LEN_W   = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2*MULT_DW-1:0]      in_mant;
    logic                      in_sign;
    logic [$clog2(A_BW)-1:0]   in_a_shamt;
    logic [$clog2(B_BW)-1:0]   in_b_shamt;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_W-1:0]          out_data;
    logic [LEN_W-1:0]          out_count;
    logic                      out_ovf;

    modport master (
        output in_valid, in_mant, in_sign, in_a_shamt, in_b_shamt, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_mant, in_sign, in_a_shamt, in_b_shamt, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/drum_result_decoder.sv
// drum_result_decoder
//   Re-expands truncated DRUM mantissa products (shift by the summed operand
//   truncation amounts, apply sign), accumulates one packet of terms and
//   presents the signed sum over a valid/ready handshake.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  drum_result_decoder_if.slave (beat in, result out)
//   Configuration macro:
//     DRUM_SATURATE_EN  defined   -> accumulator clamps on overflow and stays
//                                    clamped until the packet is cleared
//                       undefined -> accumulator wraps modulo 2^ACC_W
//   out_ovf is reported in both builds.
module drum_result_decoder #(
    parameter int MULT_DW = 4,
    parameter int A_BW    = 8,
    parameter int B_BW    = 8,
    parameter int ACC_W   = 24,
    parameter int LEN_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    drum_result_decoder_if.slave bus
);
    localparam int TW  = A_BW + B_BW;
    localparam int SAW = $clog2(A_BW);
    localparam int SBW = $clog2(B_BW);
    localparam int SW  = ((SAW > SBW) ? SAW : SBW) + 1;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s1_term_q;
    logic               s1_valid_q, s1_last_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q;
    logic [LEN_W-1:0]   out_count_q;
    logic               out_ovf_q;

    logic               in_ready, accept, clr, load_out;

    // ---------------- decode ----------------
    logic [SW-1:0]      shamt;
    logic [TW-1:0]      mag;
    logic [ACC_W-1:0]   term_ext, term_dec;

    assign shamt    = SW'(bus.in_a_shamt) + SW'(bus.in_b_shamt);
    assign mag      = TW'(bus.in_mant) << shamt;
    assign term_ext = ACC_W'(mag);
    // Negating zero yields zero, so a zero mantissa ignores the sign.
    assign term_dec = bus.in_sign ? -term_ext : term_ext;
    assign accept   = bus.in_valid && in_ready;

    // ---------------- FSM ----------------
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        clr      = 1'b0;
        load_out = 1'b0;
        unique case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (accept && bus.in_last) state_d = DRAIN;
            end
            DRAIN: begin
                // Wait one cycle for the last term to leave stage 1, so the
                // accumulator is final when the outputs are loaded.
                if (!(s1_valid_q && s1_last_q)) begin
                    load_out = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    clr     = 1'b1;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // ---------------- accumulate ----------------
    logic [ACC_W-1:0] sum;
    logic             ovf_now;

    assign sum     = acc_q + s1_term_q;
    assign ovf_now = (acc_q[ACC_W-1] == s1_term_q[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (s1_valid_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef DRUM_SATURATE_EN
            // Once clamped the accumulator is frozen for the rest of the packet.
            if (!ovf_q) begin
                if (ovf_now) begin
                    ovf_d = 1'b1;
                    acc_d = acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    acc_d = sum;
                end
            end
`else
            acc_d = sum;
            if (ovf_now) ovf_d = 1'b1;
`endif
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            s1_term_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_term_q <= term_dec;
                s1_last_q <= bus.in_last;
            end
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (load_out) begin
                out_data_q  <= acc_q;
                out_count_q <= cnt_q;
                out_ovf_q   <= ovf_q;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_drum_result_decoder.sv
module tb_drum_result_decoder;
    localparam int W0 = 24;
    localparam int W1 = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic       in_valid = 0, in_sign = 0, in_last = 0, out_ready = 0;
    logic [7:0] in_mant = 0;
    logic [2:0] a_sh = 0, b_sh = 0;

    drum_result_decoder_if #(.ACC_W(W0)) if0 ();
    drum_result_decoder_if #(.ACC_W(W1)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.in_mant  = in_mant;   assign if1.in_mant  = in_mant;
    assign if0.in_sign  = in_sign;   assign if1.in_sign  = in_sign;
    assign if0.in_a_shamt = a_sh;    assign if1.in_a_shamt = a_sh;
    assign if0.in_b_shamt = b_sh;    assign if1.in_b_shamt = b_sh;
    assign if0.in_last  = in_last;   assign if1.in_last  = in_last;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

    drum_result_decoder #(.ACC_W(W0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    drum_result_decoder #(.ACC_W(W1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // beat table and reference model state
    int     bm [300];
    bit     bs [300];
    int     ba [300];
    int     bb [300];
    longint terms [$];
    int     first_cyc, last_cyc, rise_cyc;
    logic [W0-1:0] e0;
    logic [W1-1:0] e1;
    bit     eo0, eo1;
    int     ecnt;

    // Packet sum from the arithmetic rules: terms added as integers, then
    // wrapped (or clamped and frozen) into a W-bit signed range.
    function automatic void model(input int w, output longint res, output bit ovf);
        longint hi   = (longint'(1) <<< (w - 1)) - 1;
        longint lo   = -(longint'(1) <<< (w - 1));
        longint span = longint'(1) <<< w;
        longint s    = 0;
        ovf = 0;
        foreach (terms[i]) begin
            longint n;
            n = s + terms[i];
`ifdef DRUM_SATURATE_EN
            if (!ovf) begin
                if (n > hi) begin s = hi; ovf = 1; end
                else if (n < lo) begin s = lo; ovf = 1; end
                else s = n;
            end
`else
            if (n > hi) begin ovf = 1; n = n - span; end
            else if (n < lo) begin ovf = 1; n = n + span; end
            s = n;
`endif
        end
        res = s;
    endfunction

    task automatic expect_pkt();
        longint r0, r1;
        model(W0, r0, eo0);
        model(W1, r1, eo1);
        e0   = r0[W0-1:0];
        e1   = r1[W1-1:0];
        ecnt = (terms.size() > 255) ? 255 : terms.size();
    endtask

    task automatic set_beat(input int i, input int m, input bit s, input int a, input int b);
        bm[i] = m; bs[i] = s; ba[i] = a; bb[i] = b;
    endtask

    task automatic rand_beat(input int i);
        set_beat(i, $urandom_range(0, 225), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4), $urandom_range(0, 4));
    endtask

    // Drive n beats from the table, waiting (bounded) for in_ready on each.
    task automatic drive_beats(input int n, input bit with_last, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int g;
            int t;
            longint mag;
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (g) begin in_valid = 0; @(posedge clk); #1; end
            in_valid = 1; in_mant = 8'(bm[i]); in_sign = bs[i];
            a_sh = 3'(ba[i]); b_sh = 3'(bb[i]);
            in_last = with_last && (i == n - 1);
            t = 0;
            while (!if0.in_ready && t < 100) begin @(posedge clk); #1; t++; end
            if (t >= 100) begin
                errors++; checks++;
                $display("FAIL accept_timeout beat %0d: in_ready stayed %b, required 1", i, if0.in_ready);
            end
            mag = longint'(bm[i]) * (longint'(1) <<< (ba[i] + bb[i]));
            terms.push_back(bs[i] ? -mag : mag);
            @(posedge clk); #1;
            if (i == 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (!if0.out_valid && t < 50) begin @(posedge clk); #1; t++; end
        if (!if0.out_valid) begin
            errors++; checks++;
            $display("FAIL result_timeout: out_valid stayed 0, required 1");
        end
        rise_cyc = cyc;
    endtask

    task automatic release_result();
        out_ready = 1; @(posedge clk); #1; out_ready = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_in: got %b need 0", if0.out_valid); end
        rst = 0;
        @(posedge clk); #1;
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b need 1", if0.in_ready); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b need 0", if0.out_valid); end
        checks++; if (if0.out_data !== '0) begin errors++; $display("FAIL rst_data: got %h need 0", if0.out_data); end
        checks++; if (if0.out_count !== '0) begin errors++; $display("FAIL rst_count: got %0d need 0", if0.out_count); end
        checks++; if (if0.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b need 0", if0.out_ovf); end
    endtask

    task automatic test_sign_mix();
        terms.delete();
        set_beat(0, 9, 0, 0, 0);
        set_beat(1, 12, 1, 1, 2);
        drive_beats(2, 1, 0);
        expect_pkt();
        wait_result();
        checks++; if (if0.out_data !== 24'hFFFFA9) begin errors++; $display("FAIL mix_data: got %h need ffffa9", if0.out_data); end
        checks++; if (if1.out_data !== e1) begin errors++; $display("FAIL mix_data17: got %h need %h", if1.out_data, e1); end
        checks++; if (if0.out_count !== 8'd2) begin errors++; $display("FAIL mix_count: got %0d need 2", if0.out_count); end
        checks++; if (if0.out_ovf !== 1'b0) begin errors++; $display("FAIL mix_ovf: got %b need 0", if0.out_ovf); end
        checks++; if (rise_cyc - last_cyc != 2) begin errors++; $display("FAIL mix_latency: got %0d need 2", rise_cyc - last_cyc); end
        release_result();
        checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
            errors++; $display("FAIL mix_handoff: in_ready %b out_valid %b need 1 0", if0.in_ready, if0.out_valid); end
    endtask

    task automatic test_zero_term();
        terms.delete();
        set_beat(0, 0, 1, 3, 3);
        drive_beats(1, 1, 0);
        wait_result();
        checks++; if (if0.out_data !== '0) begin errors++; $display("FAIL zero_data: got %h need 0", if0.out_data); end
        checks++; if (if0.out_count !== 8'd1) begin errors++; $display("FAIL zero_count: got %0d need 1", if0.out_count); end
        checks++; if (rise_cyc - last_cyc != 2) begin errors++; $display("FAIL zero_latency: got %0d need 2", rise_cyc - last_cyc); end
        release_result();
    endtask

    task automatic test_overflow();
        logic [W1-1:0] want1;
`ifdef DRUM_SATURATE_EN
        want1 = 17'h0FFFF;
`else
        want1 = 17'h1C200;
`endif
        terms.delete();
        set_beat(0, 225, 0, 4, 4);
        set_beat(1, 225, 0, 4, 4);
        drive_beats(2, 1, 0);
        wait_result();
        checks++; if (if1.out_data !== want1) begin errors++; $display("FAIL ovf_data17: got %h need %h", if1.out_data, want1); end
        checks++; if (if1.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag17: got %b need 1", if1.out_ovf); end
        checks++; if (if0.out_data !== 24'h01C200) begin errors++; $display("FAIL ovf_data24: got %h need 01c200", if0.out_data); end
        checks++; if (if0.out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_flag24: got %b need 0", if0.out_ovf); end
        release_result();
    endtask

    task automatic test_backpressure();
        terms.delete();
        for (int i = 0; i < 3; i++) rand_beat(i);
        drive_beats(3, 1, 0);
        expect_pkt();
        wait_result();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; in_mant = 8'($urandom_range(1, 225)); in_sign = 0; a_sh = 3'd2; b_sh = 3'd2; in_last = 1'(k & 1);
            @(posedge clk); #1;
            checks++; if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hs%0d: in_ready %b out_valid %b need 0 1", k, if0.in_ready, if0.out_valid); end
            checks++; if (if0.out_data !== e0 || if1.out_data !== e1) begin
                errors++; $display("FAIL bp_stable%0d: got %h/%h need %h/%h", k, if0.out_data, if1.out_data, e0, e1); end
        end
        in_valid = 0; in_last = 0;
        release_result();
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b need 1", if0.in_ready); end
        terms.delete();
        set_beat(0, 5, 0, 1, 0);
        set_beat(1, 3, 1, 0, 0);
        drive_beats(2, 1, 0);
        expect_pkt();
        wait_result();
        checks++; if (if0.out_data !== e0) begin errors++; $display("FAIL bp_next_data: got %h need %h", if0.out_data, e0); end
        checks++; if (if0.out_count !== 8'd2) begin errors++; $display("FAIL bp_next_count: got %0d need 2", if0.out_count); end
        release_result();
    endtask

    task automatic test_reset_mid();
        terms.delete();
        for (int i = 0; i < 4; i++) set_beat(i, 200, 0, 3, 3);
        drive_beats(2, 0, 0);
        rst = 1; #2;
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b need 0", if0.out_valid); end
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;
        checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_state: in_ready %b out_valid %b need 1 0", if0.in_ready, if0.out_valid); end
        terms.delete();
        set_beat(0, 1, 0, 0, 0);
        drive_beats(1, 1, 0);
        wait_result();
        checks++; if (if0.out_data !== 24'd1) begin errors++; $display("FAIL rmid_data: got %h need 1", if0.out_data); end
        checks++; if (if0.out_count !== 8'd1) begin errors++; $display("FAIL rmid_count: got %0d need 1", if0.out_count); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int ks [2] = '{3, 1};
        out_ready = 1;
        for (int p = 0; p < 2; p++) begin
            terms.delete();
            for (int i = 0; i < ks[p]; i++) rand_beat(i);
            drive_beats(ks[p], 1, 0);
            expect_pkt();
            wait_result();
            checks++; if (rise_cyc - first_cyc + 1 != ks[p] + 2) begin
                errors++; $display("FAIL b2b_cost%0d: got %0d need %0d", p, rise_cyc - first_cyc + 1, ks[p] + 2); end
            checks++; if (if0.out_count !== 8'(ks[p])) begin errors++; $display("FAIL b2b_count%0d: got %0d need %0d", p, if0.out_count, ks[p]); end
            checks++; if (if0.out_data !== e0) begin errors++; $display("FAIL b2b_data%0d: got %h need %h", p, if0.out_data, e0); end
            @(posedge clk); #1;
            checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_rearm%0d: in_ready %b out_valid %b need 1 0", p, if0.in_ready, if0.out_valid); end
        end
        out_ready = 0;
    endtask

    task automatic test_count_sat();
        terms.delete();
        for (int i = 0; i < 260; i++) set_beat(i, (i == 7) ? 4 : 0, 0, 0, 0);
        drive_beats(260, 1, 0);
        wait_result();
        checks++; if (if0.out_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d need 255", if0.out_count); end
        checks++; if (if0.out_data !== 24'd4) begin errors++; $display("FAIL sat_data: got %h need 4", if0.out_data); end
        release_result();
    endtask

    task automatic test_random();
        for (int p = 0; p < 30; p++) begin
            int n;
            n = $urandom_range(1, 6);
            terms.delete();
            for (int i = 0; i < n; i++) rand_beat(i);
            drive_beats(n, 1, 2);
            expect_pkt();
            wait_result();
            checks++; if (if0.out_data !== e0) begin errors++; $display("FAIL rnd%0d_data24: got %h need %h", p, if0.out_data, e0); end
            checks++; if (if1.out_data !== e1) begin errors++; $display("FAIL rnd%0d_data17: got %h need %h", p, if1.out_data, e1); end
            checks++; if (if0.out_ovf !== eo0 || if1.out_ovf !== eo1) begin
                errors++; $display("FAIL rnd%0d_ovf: got %b/%b need %b/%b", p, if0.out_ovf, if1.out_ovf, eo0, eo1); end
            checks++; if (if0.out_count !== 8'(ecnt)) begin errors++; $display("FAIL rnd%0d_count: got %0d need %0d", p, if0.out_count, ecnt); end
            checks++; if (rise_cyc - last_cyc != 2) begin errors++; $display("FAIL rnd%0d_latency: got %0d need 2", p, rise_cyc - last_cyc); end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                checks++; if (if0.out_valid !== 1'b1 || if1.out_data !== e1) begin
                    errors++; $display("FAIL rnd%0d_hold: out_valid %b data %h need 1 %h", p, if0.out_valid, if1.out_data, e1); end
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_sign_mix();
        test_zero_term();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_count_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
